// File: rtl/timing_control_unit.sv
// Instruction register and timing counter sequencer for the cpu6502 decoder; opcode lands in o_ir one cycle after SYNC.
// Stalls only while i_rdy=0 on read cycles. Define JAM_DETECT_EN to halt on TCU overflow instead of ending the instruction.
module timing_control_unit #(
   parameter logic [7:0] OPCODE_BRK = 8'h00,
   parameter logic [2:0] TCU_MAX    = 3'd7
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_rdy,
   input  logic       i_rw,
   input  logic [7:0] i_data,
   input  logic [2:0] i_tcu_next,
   input  logic       i_done,
   input  logic       i_nmi_n,
   input  logic       i_irq_n,
   input  logic       i_flag_i,
   output logic [7:0] o_ir,
   output logic [2:0] o_tcu,
   output logic       o_sync,
   output logic [1:0] o_int_source,
   output logic       o_nmi_pending,
   output logic       o_jam
);

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_JAM} state_t;

   localparam logic [1:0] SRC_OPCODE = 2'b00;
   localparam logic [1:0] SRC_IRQ    = 2'b01;
   localparam logic [1:0] SRC_NMI    = 2'b10;
   localparam logic [1:0] SRC_RESET  = 2'b11;

   state_t     state_q;
   logic [7:0] ir_q;
   logic [2:0] tcu_q;
   logic       sync_q;
   logic [1:0] src_q;
   logic       nmi_prev_q;
   logic       nmi_pend_q;
   logic       nmi_pend_d;
   logic       int_lat_q;

   logic advance;
   logic nmi_fall;
   logic nmi_clr;
   logic irq_req;
   logic overflow;
   logic instr_end;

   assign advance  = i_rdy | ~i_rw;
   assign nmi_fall = nmi_prev_q & ~i_nmi_n;
   assign irq_req  = ~i_irq_n & ~i_flag_i;
   assign overflow = ~i_done & (tcu_q == TCU_MAX);
   assign nmi_clr  = (state_q == ST_FETCH) & advance & int_lat_q & nmi_pend_q;
   // A new edge arriving on the service edge must not be lost.
   assign nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_fall;

`ifdef JAM_DETECT_EN
   logic jam_q;
   assign instr_end = i_done;
   assign o_jam     = jam_q;
`else
   assign instr_end = i_done | overflow;
   assign o_jam     = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_EXEC;
         ir_q       <= 8'h00;
         tcu_q      <= 3'd1;
         sync_q     <= 1'b0;
         src_q      <= SRC_RESET;
         nmi_prev_q <= 1'b1;
         nmi_pend_q <= 1'b0;
         int_lat_q  <= 1'b0;
`ifdef JAM_DETECT_EN
         jam_q      <= 1'b0;
`endif
      end else begin
         nmi_prev_q <= i_nmi_n;
         nmi_pend_q <= nmi_pend_d;
         case (state_q)
            ST_FETCH: begin
               if (advance) begin
                  if (int_lat_q) begin
                     ir_q  <= OPCODE_BRK;
                     src_q <= nmi_pend_q ? SRC_NMI : SRC_IRQ;
                  end else begin
                     ir_q  <= i_data;
                     src_q <= SRC_OPCODE;
                  end
                  tcu_q   <= 3'd1;
                  sync_q  <= 1'b0;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (advance) begin
                  if (instr_end) begin
                     tcu_q     <= 3'd0;
                     sync_q    <= 1'b1;
                     state_q   <= ST_FETCH;
                     int_lat_q <= nmi_pend_q | irq_req;
                  end else if (!overflow) begin
                     tcu_q <= i_tcu_next;
                  end
`ifdef JAM_DETECT_EN
                  else begin
                     state_q <= ST_JAM;
                     jam_q   <= 1'b1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ir          = ir_q;
   assign o_tcu         = tcu_q;
   assign o_sync        = sync_q;
   assign o_int_source  = src_q;
   assign o_nmi_pending = nmi_pend_q;

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed bench for timing_control_unit: per-cycle reference model comparison plus literal spot checks.
module tb_timing_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rdy = 1'b1, rw = 1'b1, done = 1'b0;
   logic       nmi_n = 1'b1, irq_n = 1'b1, flag_i = 1'b1;
   logic [7:0] data = 8'hEA;
   logic [2:0] tcu_next = 3'd0;
   logic [7:0] ir;
   logic [2:0] tcu;
   logic       sync, nmi_pending, jam;
   logic [1:0] int_source;

   int errors = 0;
   int checks = 0;
   int done_at = 6;
   bit chk_en = 1'b0;

`ifdef JAM_DETECT_EN
   localparam bit JAM_BUILD = 1'b1;
`else
   localparam bit JAM_BUILD = 1'b0;
`endif

   timing_control_unit dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_rdy(rdy), .i_rw(rw), .i_data(data),
      .i_tcu_next(tcu_next), .i_done(done), .i_nmi_n(nmi_n), .i_irq_n(irq_n),
      .i_flag_i(flag_i), .o_ir(ir), .o_tcu(tcu), .o_sync(sync),
      .o_int_source(int_source), .o_nmi_pending(nmi_pending), .o_jam(jam)
   );

   always #5 clk = ~clk;

   // Reference model: what the sequencer must show, step by step.
   logic [7:0] m_ir = 8'h00;
   int         m_tcu = 1;
   bit         m_fetching = 1'b0;
   logic [1:0] m_src = 2'b11;
   bit         m_pend = 1'b0, m_want_int = 1'b0, m_jam = 1'b0, m_nmi_last = 1'b1;

   task automatic model_edge();
      bit edge_seen;
      if (!rst_n) begin
         m_ir = 8'h00; m_tcu = 1; m_fetching = 1'b0; m_src = 2'b11;
         m_pend = 1'b0; m_want_int = 1'b0; m_jam = 1'b0; m_nmi_last = 1'b1;
         return;
      end
      edge_seen = m_nmi_last && !nmi_n;
      m_nmi_last = nmi_n;
      if (!m_jam && (rdy || !rw)) begin
         if (m_fetching) begin
            if (m_want_int && m_pend) begin m_ir = 8'h00; m_src = 2'b10; m_pend = 1'b0; end
            else if (m_want_int)       begin m_ir = 8'h00; m_src = 2'b01; end
            else                       begin m_ir = data;  m_src = 2'b00; end
            m_tcu = 1;
            m_fetching = 1'b0;
         end else if (done || (m_tcu == 7 && !JAM_BUILD)) begin
            m_want_int = m_pend || (!irq_n && !flag_i);
            m_tcu = 0;
            m_fetching = 1'b1;
         end else if (m_tcu == 7) begin
            m_jam = 1'b1;
         end else begin
            m_tcu = int'(tcu_next);
         end
      end
      if (edge_seen) m_pend = 1'b1;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_edge();
   end

   // Decoder stand-in: counts up and signals the last cycle at done_at.
   initial forever begin
      @(negedge clk);
      tcu_next = 3'(m_tcu + 1);
      done = !m_fetching && (m_tcu == done_at);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("model_ir", ir, m_ir);
         chk("model_tcu", 8'(tcu), 8'(m_tcu));
         chk("model_sync", 8'(sync), 8'(m_fetching));
         chk("model_src", 8'(int_source), 8'(m_src));
         chk("model_nmi_pending", 8'(nmi_pending), 8'(m_pend));
         chk("model_jam", 8'(jam), 8'(m_jam));
      end
   end

   task automatic wait_fetch(input string name);
      for (int n = 0; n < 20; n++) begin
         if (sync === 1'b1) return;
         @(negedge clk);
      end
      chk({name, "_timeout"}, 8'd0, 8'd1);
   endtask

   task automatic wait_tcu(input logic [2:0] v);
      for (int n = 0; n < 20; n++) begin
         if (tcu === v) return;
         @(negedge clk);
      end
      chk("wait_tcu_timeout", 8'd0, 8'd1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ir", ir, 8'h00);
      chk("rst_tcu", 8'(tcu), 8'd1);
      chk("rst_sync", 8'(sync), 8'd0);
      chk("rst_src", 8'(int_source), 8'd3);
      rst_n = 1'b1;

      // Reset sequence runs 1..6 then fetches
      for (int k = 1; k <= 6; k++) begin
         chk("rstseq_tcu", 8'(tcu), 8'(k));
         chk("rstseq_src", 8'(int_source), 8'd3);
         @(negedge clk);
      end
      chk("rstseq_end_tcu", 8'(tcu), 8'd0);
      chk("rstseq_end_sync", 8'(sync), 8'd1);

      // Plain opcode fetch
      data = 8'h8D;
      @(negedge clk);
      chk("fetch_ir", ir, 8'h8D);
      chk("fetch_tcu", 8'(tcu), 8'd1);
      chk("fetch_sync", 8'(sync), 8'd0);
      chk("fetch_src", 8'(int_source), 8'd0);
      data = 8'hEA;

      // RDY stall on reads holds, ignored on writes
      @(negedge clk);
      chk("pre_stall_tcu", 8'(tcu), 8'd2);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_read_tcu", 8'(tcu), 8'd2);
      end
      rw = 1'b0;
      @(negedge clk);
      chk("stall_write_tcu", 8'(tcu), 8'd3);
      rdy = 1'b1; rw = 1'b1;
      wait_fetch("stall");

      // NMI wins over a simultaneous unmasked IRQ
      data = 8'hA9;
      @(negedge clk);
      chk("nmi_pre_ir", ir, 8'hA9);
      nmi_n = 1'b0; irq_n = 1'b0; flag_i = 1'b0;
      @(negedge clk);
      chk("nmi_latched", 8'(nmi_pending), 8'd1);
      wait_fetch("nmi");
      @(negedge clk);
      chk("nmi_ir", ir, 8'h00);
      chk("nmi_src", 8'(int_source), 8'd2);
      chk("nmi_cleared", 8'(nmi_pending), 8'd0);
      nmi_n = 1'b1; irq_n = 1'b1; flag_i = 1'b1; data = 8'hEA;
      wait_fetch("brk_end");
      @(negedge clk);

      // Masked IRQ is ignored, unmasked IRQ is injected
      irq_n = 1'b0; flag_i = 1'b1;
      wait_fetch("irq_masked");
      @(negedge clk);
      chk("irq_masked_ir", ir, 8'hEA);
      chk("irq_masked_src", 8'(int_source), 8'd0);
      flag_i = 1'b0;
      wait_fetch("irq_open");
      @(negedge clk);
      chk("irq_ir", ir, 8'h00);
      chk("irq_src", 8'(int_source), 8'd1);
      irq_n = 1'b1; flag_i = 1'b1;

      // Counter overflow without i_done
      done_at = 8;
      wait_tcu(3'd7);
      @(negedge clk);
`ifdef JAM_DETECT_EN
      chk("jam_set", 8'(jam), 8'd1);
      chk("jam_tcu", 8'(tcu), 8'd7);
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      rdy = 1'b1;
      @(negedge clk);
      chk("jam_frozen_tcu", 8'(tcu), 8'd7);
      chk("jam_frozen_sync", 8'(sync), 8'd0);
      done_at = 6;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("jam_rst", 8'(jam), 8'd0);
      rst_n = 1'b1;
`else
      chk("ovf_tcu", 8'(tcu), 8'd0);
      chk("ovf_sync", 8'(sync), 8'd1);
      chk("ovf_jam", 8'(jam), 8'd0);
      done_at = 6;
`endif
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
